// File: rtl/mpc_types.sv
// Shared types for the switch-box bank responder.
// Channel/bank counts, id types and a grant encoder.
package mpc_types;

    localparam int SWB_NUM_CH   = 3;
    localparam int SWB_NUM_BANK = 4;

    typedef logic [1:0] swb_bank_id_t;
    typedef logic [1:0] swb_ch_id_t;
    typedef logic [3:0] swb_busy_cnt_t;

    function automatic swb_ch_id_t swb_gnt_to_ch(input logic [2:0] g);
        swb_ch_id_t ch;
        unique case (1'b1)
            g[0]:    ch = 2'd0;
            g[1]:    ch = 2'd1;
            g[2]:    ch = 2'd2;
            default: ch = 2'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/swb_rr_arb3.sv
// Three-requester round-robin arbiter with enable.
// Grant is combinational; pointer advances past the winner.
module swb_rr_arb3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic       i_en,
    output logic [2:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [2:0] w_gnt;

    always_comb begin
        w_gnt = '0;
        if (i_en) begin
            unique case (r_ptr)
                2'd1: begin
                    if (i_req[1])      w_gnt = 3'b010;
                    else if (i_req[2]) w_gnt = 3'b100;
                    else if (i_req[0]) w_gnt = 3'b001;
                end
                2'd2: begin
                    if (i_req[2])      w_gnt = 3'b100;
                    else if (i_req[0]) w_gnt = 3'b001;
                    else if (i_req[1]) w_gnt = 3'b010;
                end
                default: begin
                    if (i_req[0])      w_gnt = 3'b001;
                    else if (i_req[1]) w_gnt = 3'b010;
                    else if (i_req[2]) w_gnt = 3'b100;
                end
            endcase
        end
    end

    assign o_gnt = w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else begin
            unique case (1'b1)
                w_gnt[0]: r_ptr <= 2'd1;
                w_gnt[1]: r_ptr <= 2'd2;
                w_gnt[2]: r_ptr <= 2'd0;
                default:  r_ptr <= r_ptr;
            endcase
        end
    end

endmodule

// File: rtl/swb_bank_arb.sv
// Bank-side SWB responder: per-bank round-robin grant,
// registered ack/strobe and per-bank occupancy counter.
module swb_bank_arb
    import mpc_types::*;
#(
    parameter int BUSY_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_ch_0_swb_req,
    input  swb_bank_id_t d_ch_0_swb_bank_id,
    input  logic         d_ch_1_swb_req,
    input  swb_bank_id_t d_ch_1_swb_bank_id,
    input  logic         d_ch_2_swb_req,
    input  swb_bank_id_t d_ch_2_swb_bank_id,
    output logic         d_ch_0_swb_ack,
    output logic         d_ch_1_swb_ack,
    output logic         d_ch_2_swb_ack,
    output logic [3:0]   bank_vld,
    output logic [7:0]   bank_ch_id,
    output logic [3:0]   bank_busy
);

    localparam swb_busy_cnt_t LP_BUSY_INIT =
        swb_busy_cnt_t'(BUSY_CYC - 1);

    logic [2:0]    w_req;
    swb_bank_id_t  w_bid   [SWB_NUM_CH];
    logic [2:0]    w_breq  [SWB_NUM_BANK];
    logic [2:0]    w_gnt   [SWB_NUM_BANK];
    logic [3:0]    w_en;
    logic [2:0]    w_ack_nxt;

    logic [2:0]    r_ack;
    logic [3:0]    r_vld;
    swb_ch_id_t    r_ch    [SWB_NUM_BANK];
    swb_busy_cnt_t r_busy  [SWB_NUM_BANK];

    assign w_req    = {d_ch_2_swb_req, d_ch_1_swb_req, d_ch_0_swb_req};
    assign w_bid[0] = d_ch_0_swb_bank_id;
    assign w_bid[1] = d_ch_1_swb_bank_id;
    assign w_bid[2] = d_ch_2_swb_bank_id;

    // A channel acked this cycle still holds req for the served request
    for (genvar gb = 0; gb < SWB_NUM_BANK; gb++) begin : g_bank
        for (genvar gc = 0; gc < SWB_NUM_CH; gc++) begin : g_ch
            assign w_breq[gb][gc] = w_req[gc] & ~r_ack[gc] &
                (w_bid[gc] == swb_bank_id_t'(gb));
        end
        assign w_en[gb]      = (r_busy[gb] == '0);
        assign bank_busy[gb] = (r_busy[gb] != '0);

        swb_rr_arb3 u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_req (w_breq[gb]),
            .i_en  (w_en[gb]),
            .o_gnt (w_gnt[gb])
        );
    end

    always_comb begin
        w_ack_nxt = '0;
        for (int b = 0; b < SWB_NUM_BANK; b++) begin
            w_ack_nxt = w_ack_nxt | w_gnt[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= '0;
            r_vld <= '0;
            for (int b = 0; b < SWB_NUM_BANK; b++) begin
                r_ch[b]   <= '0;
                r_busy[b] <= '0;
            end
        end else begin
            r_ack <= w_ack_nxt;
            for (int b = 0; b < SWB_NUM_BANK; b++) begin
                r_vld[b] <= |w_gnt[b];
                r_ch[b]  <= swb_gnt_to_ch(w_gnt[b]);
                if (|w_gnt[b]) begin
                    r_busy[b] <= LP_BUSY_INIT;
                end else if (r_busy[b] != '0) begin
                    r_busy[b] <= r_busy[b] - 4'd1;
                end
            end
        end
    end

    assign d_ch_0_swb_ack = r_ack[0];
    assign d_ch_1_swb_ack = r_ack[1];
    assign d_ch_2_swb_ack = r_ack[2];
    assign bank_vld       = r_vld;
    assign bank_ch_id     = {r_ch[3], r_ch[2], r_ch[1], r_ch[0]};

endmodule

// File: tb/tb_swb_bank_arb.sv
// Bench for swb_bank_arb: two instances (BUSY_CYC 2 and 1)
// checked every cycle against a behavioural model.
module tb_swb_bank_arb;

    logic       clk;
    logic       rst_n;
    logic [2:0] req [2];
    logic [1:0] bid [2][3];

    logic       a0, a1, a2, b0, b1, b2;
    logic [2:0] d_ack  [2];
    logic [3:0] d_vld  [2];
    logic [3:0] d_busy [2];
    logic [7:0] d_ch   [2];

    int n_chk = 0;
    int n_pass = 0;

    logic [2:0] m_ack [2];
    logic [3:0] m_vld [2];
    int         m_ch  [2][4];
    int         m_cnt [2][4];
    int         m_ptr [2][4];

    swb_bank_arb #(.BUSY_CYC(2)) u_dut_a (
        .clk                (clk),
        .rst_n              (rst_n),
        .d_ch_0_swb_req     (req[0][0]),
        .d_ch_0_swb_bank_id (bid[0][0]),
        .d_ch_1_swb_req     (req[0][1]),
        .d_ch_1_swb_bank_id (bid[0][1]),
        .d_ch_2_swb_req     (req[0][2]),
        .d_ch_2_swb_bank_id (bid[0][2]),
        .d_ch_0_swb_ack     (a0),
        .d_ch_1_swb_ack     (a1),
        .d_ch_2_swb_ack     (a2),
        .bank_vld           (d_vld[0]),
        .bank_ch_id         (d_ch[0]),
        .bank_busy          (d_busy[0])
    );

    swb_bank_arb #(.BUSY_CYC(1)) u_dut_b (
        .clk                (clk),
        .rst_n              (rst_n),
        .d_ch_0_swb_req     (req[1][0]),
        .d_ch_0_swb_bank_id (bid[1][0]),
        .d_ch_1_swb_req     (req[1][1]),
        .d_ch_1_swb_bank_id (bid[1][1]),
        .d_ch_2_swb_req     (req[1][2]),
        .d_ch_2_swb_bank_id (bid[1][2]),
        .d_ch_0_swb_ack     (b0),
        .d_ch_1_swb_ack     (b1),
        .d_ch_2_swb_ack     (b2),
        .bank_vld           (d_vld[1]),
        .bank_ch_id         (d_ch[1]),
        .bank_busy          (d_busy[1])
    );

    always_comb begin
        d_ack[0] = {a2, a1, a0};
        d_ack[1] = {b2, b1, b0};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int busy_cyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Model: per bank, first eligible channel scanning from the pointer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ack[i] <= '0;
                m_vld[i] <= '0;
                for (int b = 0; b < 4; b++) begin
                    m_ch[i][b]  <= 0;
                    m_cnt[i][b] <= 0;
                    m_ptr[i][b] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [2:0] nack;
                logic [3:0] nvld;
                nack = '0;
                nvld = '0;
                for (int b = 0; b < 4; b++) begin
                    int win;
                    win = -1;
                    m_ch[i][b] <= 0;
                    if (m_cnt[i][b] > 0) begin
                        m_cnt[i][b] <= m_cnt[i][b] - 1;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            int c;
                            c = (m_ptr[i][b] + k) % 3;
                            if (win < 0 && req[i][c] && !m_ack[i][c]
                                && int'(bid[i][c]) == b)
                                win = c;
                        end
                        if (win >= 0) begin
                            nack[win]   = 1'b1;
                            nvld[b]     = 1'b1;
                            m_ch[i][b]  <= win;
                            m_ptr[i][b] <= (win + 1) % 3;
                            m_cnt[i][b] <= busy_cyc(i) - 1;
                        end
                    end
                end
                m_ack[i] <= nack;
                m_vld[i] <= nvld;
            end
        end
    end

    logic [7:0] e_ch, g_ch;
    logic [3:0] e_busy;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_ch = '0;
            g_ch = '0;
            for (int b = 0; b < 4; b++) begin
                e_busy[b] = (m_cnt[i][b] != 0);
                if (m_vld[i][b]) begin
                    e_ch[2*b +: 2] = 2'(m_ch[i][b]);
                    g_ch[2*b +: 2] = d_ch[i][2*b +: 2];
                end
            end
            n_chk++;
            if ({d_ack[i], d_vld[i], d_busy[i], g_ch} ===
                {m_ack[i], m_vld[i], e_busy, e_ch})
                n_pass++;
            else
                $display("FAIL cycle_cmp inst%0d t=%0t ack %b want %b vld %b want %b busy %b want %b ch %h want %h",
                    i, $time, d_ack[i], m_ack[i], d_vld[i], m_vld[i],
                    d_busy[i], e_busy, g_ch, e_ch);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 2; i++) req[i] = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int at [3];
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0;
            for (int c = 0; c < 3; c++) bid[i][c] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ack", int'(d_ack[0]), 0);
        chk("rst_vld", int'(d_vld[0]), 0);
        chk("rst_busy", int'(d_busy[1]), 0);
        rst_n = 1'b1;
        idle(2);

        // single request: ch1 -> bank 2 on both instances
        req[0][1] = 1'b1; bid[0][1] = 2'd2;
        req[1][1] = 1'b1; bid[1][1] = 2'd2;
        @(negedge clk);
        chk("single_ack", int'(d_ack[0]), 3'b010);
        chk("single_vld", int'(d_vld[0]), 4'b0100);
        chk("single_ch", int'(d_ch[0][5:4]), 1);
        chk("single_busy", int'(d_busy[0]), 4'b0100);
        chk("single_busy_b1", int'(d_busy[1]), 0);
        req[0][1] = 1'b0;
        req[1][1] = 1'b0;
        @(negedge clk);
        chk("single_busy_t2", int'(d_busy[0]), 0);
        chk("single_ack_t2", int'(d_ack[0]), 0);
        idle(3);

        // three-way contention on bank 0
        at = '{-1, -1, -1};
        req[0] = 3'b111;
        for (int c = 0; c < 3; c++) bid[0][c] = 2'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (d_ack[0][c] && at[c] < 0) at[c] = cyc;
                if (m_ack[0][c]) req[0][c] = 1'b0;
            end
        end
        chk("cont_ch0", at[0], 1);
        chk("cont_ch1", at[1], 3);
        chk("cont_ch2", at[2], 5);
        chk("cont_model_ptr", m_ptr[0][0], 0);
        idle(3);

        // fairness on bank 3, BUSY_CYC=1
        req[1] = 3'b101;
        bid[1][0] = 2'd3;
        bid[1][2] = 2'd3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair", int'(d_ack[1]), (k % 2 == 0) ? 1 : 4);
        end
        idle(3);

        // parallel banks
        req[0] = 3'b111;
        bid[0][0] = 2'd0; bid[0][1] = 2'd1; bid[0][2] = 2'd3;
        @(negedge clk);
        chk("par_ack", int'(d_ack[0]), 3'b111);
        chk("par_vld", int'(d_vld[0]), 4'b1011);
        chk("par_ch", int'(d_ch[0]), 8'b10_00_01_00);
        idle(3);

        // masked after ack: ch2 keeps req on bank 1
        req[0][2] = 1'b1; bid[0][2] = 2'd1;
        @(negedge clk);
        chk("mask_t1", int'(d_ack[0]), 3'b100);
        @(negedge clk);
        chk("mask_t2", int'(d_ack[0]), 0);
        @(negedge clk);
        chk("mask_t3", int'(d_ack[0]), 3'b100);
        idle(3);

        // reset while an ack is pending
        req[0][1] = 1'b1; bid[0][1] = 2'd2;
        @(posedge clk);
        #2;
        chk("pre_rst_ack", int'(d_ack[0]), 3'b010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", int'(d_ack[0]), 0);
        chk("rst_mid_vld", int'(d_vld[0]), 0);
        chk("rst_mid_busy", int'(d_busy[0]), 0);
        chk("rst_mid_ch", int'(d_ch[0]), 0);
        req[0] = 3'b111;
        for (int c = 0; c < 3; c++) bid[0][c] = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tie", int'(d_ack[0]), 3'b001);
        idle(3);

        // randomized traffic under the req/ack protocol
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 3; c++) begin
                    if (req[i][c] && m_ack[i][c]) begin
                        req[i][c] = 1'($urandom_range(1, 0));
                        bid[i][c] = 2'($urandom_range(3, 0));
                    end else if (!req[i][c] && $urandom_range(3, 0) == 0) begin
                        req[i][c] = 1'b1;
                        bid[i][c] = 2'($urandom_range(3, 0));
                    end
                end
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/swb_bank_arb.md
# swb_bank_arb

Bank-side responder for the per-channel switch-box (SWB) request interface driven by the key-order buffer. It accepts `d_ch_N_swb_req` plus `d_ch_N_swb_bank_id` from three channels and arbitrates each of four banks independently, round-robin. It returns a one-cycle `swb_ack` to the winning channel and issues a one-cycle access strobe to the bank. A per-bank busy counter models bank occupancy and blocks new grants until the bank is free.

## Interface
- NUM_CH, 3, channel count (fixed; ports are enumerated per channel)
- NUM_BANK, 4, bank count; bank_id width = 2
- BUSY_CYC, 2, cycles a bank stays busy after a grant (1..15); 1 = back-to-back grants allowed
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- d_ch_N_swb_req  in  1  channel N (N=0..2) requests a bank; held high until ack
- d_ch_N_swb_bank_id  in  2  target bank; stable while req high and unacked
- d_ch_N_swb_ack  out  1  one-cycle grant acknowledge to channel N
- bank_vld  out  4  bit b: one-cycle access strobe to bank b
- bank_ch_id  out  8  2 bits per bank, winning channel for bank b (bits 2b+1:2b)
- bank_busy  out  4  bit b: bank b currently blocked

## Operation
- Cycle t: for each bank b, candidate set = channels with req=1, bank_id=b, ack_q=0 (a channel acked this cycle is masked, since its req is still high for the request just served).
- If bank b not busy and set non-empty: winner = first candidate at or after rr_ptr[b] in order 0,1,2 with wrap. Register ack for the winner, bank_vld[b]=1, bank_ch_id[b]=winner; rr_ptr[b] <= (winner+1) mod 3; busy_cnt[b] <= BUSY_CYC-1.
- A channel targets one bank, so it wins at most one bank per cycle and acks never collide.
- busy_cnt[b] != 0 → bank_busy[b]=1, no grant; decrements by 1 per cycle, saturating at 0.
- Idle bank: rr_ptr is unchanged.
- Bank-id change while req is high and unacked is a protocol violation: the value is sampled each cycle, and no checker is built into the block.
- Reset: all acks 0, bank_vld 0, bank_ch_id 0, bank_busy 0, busy_cnt 0, rr_ptr 0. Asserting reset mid-operation drops any pending ack and strobe immediately. A requester still high after reset is re-arbitrated from ptr 0.

## Timing
- Request sampled at posedge t → ack, bank_vld and bank_ch_id high for exactly cycle t+1 (registered; latency 1).
- The channel may present a new request (any bank) in cycle t+1. Because it is masked in t+1, its earliest next ack is t+3.
- Same bank, BUSY_CYC=2: grants are at most every 2 cycles. BUSY_CYC=1: one grant per cycle per bank.
- Four banks grant in parallel; maximum 3 acks per cycle (one per channel).
- No combinational path from req to ack.

## Structure
- mpc_types: add `SWB_NUM_CH`, `SWB_NUM_BANK`, `swb_bank_id_t` (logic [1:0]), `swb_ch_id_t` (logic [1:0]).
- Sub-module `swb_rr_arb3`: 3-requester round-robin arbiter with pointer register, enable (= not busy) and one-hot grant. It is instantiated once per bank.
- The top level holds the request decode to per-bank request vectors, ack OR-reduction and registers, busy counters, and bank_ch_id encode.

## Test plan
- Single request: ch1 req bank 2 at t → d_ch_1_swb_ack=1 and bank_vld=4'b0100 at t+1, bank_ch_id[5:4]=1, bank_busy[2]=1 at t+1 (BUSY_CYC=2), 0 at t+2.
- Contention: ch0, ch1, ch2 all req bank 0, held until acked, BUSY_CYC=2 → acks in order ch0@t+1, ch1@t+3, ch2@t+5. Pointer then = 0.
- Round-robin fairness: ch0 and ch2 continuously re-request bank 3, BUSY_CYC=1 → acks alternate ch0, ch2, ch0, ...; neither is starved more than 1 grant.
- Parallel banks: ch0→b0, ch1→b1, ch2→b3 same cycle → all three acks at t+1, bank_vld=4'b1011.
- Mask after ack: ch2 holds req on bank 1 after its ack → no ack at t+2, next ack at t+3 (BUSY_CYC≤2).
- Reset mid-operation: rst_n low during a cycle with ack pending → all outputs 0 asynchronously. After release, ptrs restart at 0 (ch0 wins a 3-way tie).
